// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - ASCII constants and state encodings shared by the RTC UART paths
`timescale 1ns/1ps
package rtc_pkg;

  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_0     = 8'h30;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Each parser state names the byte it is waiting for.
  typedef enum logic [3:0] {
    P_IDLE, P_EQ, P_H1, P_H0, P_C1, P_M1, P_M0, P_C2, P_S1, P_S0, P_TERM
  } parse_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= 8'h39);
  endfunction

endpackage

// File: rtl/uart_time_set_rx_if.sv
// rtl/uart_time_set_rx_if.sv - set-time valid/ready port towards the DS1302 controller
`timescale 1ns/1ps
interface uart_time_set_rx_if;
  logic       set_valid;
  logic       set_ready;
  logic [7:0] set_hour;
  logic [7:0] set_minute;
  logic [7:0] set_second;

  modport master (output set_valid, set_hour, set_minute, set_second, input set_ready);
  modport slave  (input set_valid, set_hour, set_minute, set_second, output set_ready);
endinterface

// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - 16x oversampled 8N1 receiver with 2-FF input synchroniser
`timescale 1ns/1ps
import rtc_pkg::*;

module uart_rx_8n1 #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  output logic       frame_err
);
  localparam int          DIV      = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  rx_state_t   state, state_nxt;
  logic [15:0] div_cnt;
  logic [2:0]  sync_q;
  logic [3:0]  tcnt;
  logic [2:0]  bit_cnt;
  logic        tick, rx_s, fall, sample, strobe_d, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                         div_cnt <= div_cnt + 16'd1;
  end

  assign tick = (div_cnt == DIV_LAST);

  // sync_q[2] is a history stage used only for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 3'b111;
    else        sync_q <= {sync_q[1:0], uart_rx};
  end

  assign rx_s   = sync_q[1];
  assign fall   = sync_q[2] & ~sync_q[1];
  assign sample = tick && (tcnt == ((state == RX_START) ? 4'd7 : 4'd15));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (fall) state_nxt = RX_START;
      RX_START: if (sample) state_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (sample && (bit_cnt == 3'd7)) state_nxt = RX_STOP;
      RX_STOP:  if (sample) state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    strobe_d = 1'b0;
    ferr_d   = 1'b0;
    if ((state == RX_STOP) && sample) begin
      strobe_d = rx_s;
      ferr_d   = ~rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt      <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_strobe <= strobe_d;
      frame_err <= ferr_d;
      if ((state == RX_IDLE) || (state_nxt != state)) tcnt <= '0;
      else if (tick)                                   tcnt <= tcnt + 4'd1;
      if (state != RX_DATA) bit_cnt <= '0;
      else if (sample)      bit_cnt <= bit_cnt + 3'd1;
      if ((state == RX_DATA) && sample) rx_data <= {rx_s, rx_data[7:1]};
    end
  end
endmodule

// File: rtl/uart_time_set_rx.sv
// rtl/uart_time_set_rx.sv - parses "T=HH:MM:SS<CR|LF>" from the UART into a BCD set-time triple
`timescale 1ns/1ps
import rtc_pkg::*;

module uart_time_set_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               uart_rx,
  uart_time_set_rx_if.master set_if,
  output logic               cmd_err,
  output logic               frame_err
);
  logic [7:0]   rx_data;
  logic         rx_strobe;
  parse_state_t pstate, pstate_nxt;
  logic [3:0]   dval, h1, h0, m1, m0, s1, s0;
  logic         digit, byte_ok, term_ok, pending, load, cmd_err_d;

  uart_rx_8n1 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .rx_data(rx_data), .rx_strobe(rx_strobe), .frame_err(frame_err)
  );

  // The low nibble of an ASCII digit is its value.
  assign digit = is_digit(rx_data);
  assign dval  = rx_data[3:0];

  always_comb begin
    byte_ok = 1'b0;
    case (pstate)
      P_IDLE:       byte_ok = (rx_data == CH_T);
      P_EQ:         byte_ok = (rx_data == CH_EQ);
      P_H1:         byte_ok = digit && (dval <= 4'd2);
      P_H0:         byte_ok = digit && ((h1 != 4'd2) || (dval <= 4'd3));
      P_C1, P_C2:   byte_ok = (rx_data == CH_COLON);
      P_M1, P_S1:   byte_ok = digit && (dval <= 4'd5);
      P_M0, P_S0:   byte_ok = digit;
      P_TERM:       byte_ok = (rx_data == CH_CR) || (rx_data == CH_LF);
      default:      byte_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pstate <= P_IDLE;
    else        pstate <= pstate_nxt;
  end

  always_comb begin
    pstate_nxt = pstate;
    if (rx_strobe) begin
      if (byte_ok) pstate_nxt = (pstate == P_TERM) ? P_IDLE : parse_state_t'(pstate + 4'd1);
      else         pstate_nxt = (rx_data == CH_T) ? P_EQ : P_IDLE;
    end
  end

  // A triple still waiting for acceptance this cycle blocks the new one.
  always_comb begin
    term_ok   = rx_strobe && byte_ok && (pstate == P_TERM);
    pending   = set_if.set_valid && !set_if.set_ready;
    load      = term_ok && !pending;
    cmd_err_d = (rx_strobe && (pstate != P_IDLE) && !byte_ok) || (term_ok && pending);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {h1, h0, m1, m0, s1, s0} <= '0;
      set_if.set_valid  <= 1'b0;
      set_if.set_hour   <= '0;
      set_if.set_minute <= '0;
      set_if.set_second <= '0;
      cmd_err           <= 1'b0;
    end else begin
      cmd_err <= cmd_err_d;
      if (rx_strobe && byte_ok) begin
        case (pstate)
          P_H1:    h1 <= dval;
          P_H0:    h0 <= dval;
          P_M1:    m1 <= dval;
          P_M0:    m0 <= dval;
          P_S1:    s1 <= dval;
          P_S0:    s0 <= dval;
          default: ;
        endcase
      end
      if (load) begin
        set_if.set_hour   <= {h1, h0};
        set_if.set_minute <= {m1, m0};
        set_if.set_second <= {s1, s0};
        set_if.set_valid  <= 1'b1;
      end else if (set_if.set_valid && set_if.set_ready) begin
        set_if.set_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_time_set_rx.sv
// tb/tb_uart_time_set_rx.sv - randomized bench for uart_time_set_rx against a command-level model
`timescale 1ns/1ps
module tb_uart_time_set_rx;
  localparam int CLK_HZ   = 307_200;
  localparam int BAUD     = 9600;
  localparam int BIT_CLKS = CLK_HZ / BAUD;
  localparam logic [7:0] K_T = 8'h54, K_EQ = 8'h3D, K_COL = 8'h3A, K_CR = 8'h0D, K_LF = 8'h0A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx = 1'b1;
  logic cmd_err, frame_err;

  uart_time_set_rx_if sif();

  uart_time_set_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .set_if(sif), .cmd_err(cmd_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int exp_cmd_err = 0, exp_frame_err = 0, got_cmd_err = 0, got_frame_err = 0;
  int acc_cnt = 0, valid_cycles = 0;
  logic [23:0] exp_q[$];
  logic [23:0] last_acc = '0;
  logic [7:0]  cmd [0:10];
  int pos = -1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Command-level model: field limits are numeric ranges on the partial value.
  function automatic bit char_ok(input int p, input logic [7:0] b);
    int lim, d;
    if (p == 1) return b == K_EQ;
    if (p == 4 || p == 7) return b == K_COL;
    if (p == 10) return (b == K_CR) || (b == K_LF);
    if (b < 8'h30 || b > 8'h39) return 1'b0;
    lim = (p < 5) ? 23 : 59;
    d = int'(b) - 48;
    if (p % 3 == 2) return d * 10 <= lim;
    return (int'(cmd[p-1]) - 48) * 10 + d <= lim;
  endfunction

  function automatic logic [7:0] bcd2(input logic [7:0] a, input logic [7:0] b);
    return 8'((int'(a) - 48) * 16 + (int'(b) - 48));
  endfunction

  task automatic model_byte(input logic [7:0] b);
    if (pos < 0) begin
      if (b == K_T) pos = 1;
    end else if (char_ok(pos, b)) begin
      cmd[pos] = b;
      pos++;
      if (pos == 11) begin
        pos = -1;
        if (exp_q.size() != 0) exp_cmd_err++;
        else exp_q.push_back({bcd2(cmd[2], cmd[3]), bcd2(cmd[5], cmd[6]), bcd2(cmd[8], cmd[9])});
      end
    end else begin
      exp_cmd_err++;
      pos = (b == K_T) ? 1 : -1;
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    if (stop) model_byte(b);
    else      exp_frame_err++;
    uart_rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_clks(BIT_CLKS);
    end
    uart_rx = stop;
    wait_clks(BIT_CLKS);
    uart_rx = 1'b1;
    if (!stop) wait_clks(BIT_CLKS);
    wait_clks(1 + int'($urandom_range(0, 5)));
    check("cmd_err_count", got_cmd_err, exp_cmd_err);
    check("frame_err_count", got_frame_err, exp_frame_err);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  initial begin : monitor
    logic [23:0] trip, held;
    bit hold;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      trip = {sif.set_hour, sif.set_minute, sif.set_second};
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (cmd_err) got_cmd_err++;
        if (frame_err) got_frame_err++;
        if (sif.set_valid) valid_cycles++;
        if (hold) check("pending_stable", {7'd0, sif.set_valid, trip}, {7'd0, 1'b1, held});
        if (sif.set_valid && sif.set_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_accept: got %06h, required no transfer", trip);
          end else begin
            check("accept_triple", {8'd0, trip}, {8'd0, exp_q.pop_front()});
          end
          last_acc = trip;
          acc_cnt++;
          hold = 1'b0;
        end else begin
          hold = sif.set_valid;
          held = trip;
        end
      end
    end
  end

  initial begin : stimulus
    int c0, a0, v0, r;
    sif.set_ready = 1'b0;
    wait_clks(4);
    check("reset_outputs", {5'd0, sif.set_valid, cmd_err, frame_err, sif.set_hour, sif.set_minute, sif.set_second}, 32'd0);
    rst_n = 1'b1;
    wait_clks(BIT_CLKS);

    // 1: basic command, immediate acceptance
    sif.set_ready = 1'b1;
    v0 = valid_cycles; c0 = got_cmd_err;
    send_str("T=12:34:56"); send_byte(K_CR, 1'b1);
    check("t1_triple", {8'd0, last_acc}, 32'h123456);
    check("t1_valid_cycles", valid_cycles - v0, 1);
    check("t1_no_cmd_err", got_cmd_err - c0, 0);

    // 2: boundary values, both terminators
    send_str("T=23:59:59"); send_byte(K_LF, 1'b1);
    check("t2_max", {8'd0, last_acc}, 32'h235959);
    send_str("T=00:00:00"); send_byte(K_CR, 1'b1);
    check("t2_min", {8'd0, last_acc}, 32'h000000);

    // 3: hour 24 rejected at H0; short hour rejected at ':'
    a0 = acc_cnt; c0 = got_cmd_err;
    send_str("T=2");
    check("t3_before_h0", got_cmd_err - c0, 0);
    send_str("4:00:00"); send_byte(K_CR, 1'b1);
    check("t3_h0_err", got_cmd_err - c0, 1);
    send_str("T=1:");
    check("t3_colon_err", got_cmd_err - c0, 2);
    check("t3_no_accept", acc_cnt - a0, 0);

    // 4: second command dropped while first is pending
    sif.set_ready = 1'b0;
    c0 = got_cmd_err;
    send_str("T=01:02:03"); send_byte(K_CR, 1'b1);
    send_str("T=04:05:06"); send_byte(K_CR, 1'b1);
    check("t4_pending", {7'd0, sif.set_valid, sif.set_hour, sif.set_minute, sif.set_second}, {7'd0, 1'b1, 24'h010203});
    check("t4_drop_err", got_cmd_err - c0, 1);
    sif.set_ready = 1'b1;
    wait_clks(4);
    check("t4_accepted", {8'd0, last_acc}, 32'h010203);
    check("t4_valid_low", {31'd0, sif.set_valid}, 32'd0);

    // 5: bad stop bit drops the byte only; short glitch is ignored
    c0 = got_frame_err;
    send_str("T=");
    send_byte(8'h31, 1'b0);
    send_str("12:34:56"); send_byte(K_CR, 1'b1);
    check("t5_frame_err", got_frame_err - c0, 1);
    check("t5_triple", {8'd0, last_acc}, 32'h123456);
    send_str("T=1");
    uart_rx = 1'b0;
    wait_clks(BIT_CLKS / 4);
    uart_rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("glitch_cmd_err", got_cmd_err, exp_cmd_err);
    check("glitch_frame_err", got_frame_err, exp_frame_err);
    send_str("2:00:00"); send_byte(K_LF, 1'b1);
    check("t5_after_glitch", {8'd0, last_acc}, 32'h120000);

    // 6: reset in the middle of a byte discards the partial command
    send_str("T=12:");
    uart_rx = 1'b0;
    wait_clks(BIT_CLKS);
    uart_rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    rst_n = 1'b0;
    pos = -1;
    exp_q.delete();
    wait_clks(3);
    check("t6_reset_outputs", {5'd0, sif.set_valid, cmd_err, frame_err, sif.set_hour, sif.set_minute, sif.set_second}, 32'd0);
    rst_n = 1'b1;
    wait_clks(BIT_CLKS);
    a0 = acc_cnt;
    send_str("T=10:20:30"); send_byte(K_CR, 1'b1);
    check("t6_triple", {8'd0, last_acc}, 32'h102030);
    check("t6_one_accept", acc_cnt - a0, 1);

    // Randomized commands: out-of-range digits, bad terminators, junk, stalls
    for (int n = 0; n < 4; n++) begin
      sif.set_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) send_byte(8'($urandom_range(0, 255)), 1'b1);
      send_byte(K_T, 1'b1);
      send_byte(K_EQ, 1'b1);
      send_byte(8'(48 + $urandom_range(0, 3)), 1'b1);
      send_byte(8'(48 + $urandom_range(0, 9)), 1'b1);
      send_byte(K_COL, 1'b1);
      send_byte(8'(48 + $urandom_range(0, 6)), 1'b1);
      send_byte(8'(48 + $urandom_range(0, 9)), 1'b1);
      send_byte(K_COL, 1'b1);
      send_byte(8'(48 + $urandom_range(0, 6)), 1'b1);
      send_byte(8'(48 + $urandom_range(0, 9)), 1'b1);
      r = int'($urandom_range(0, 3));
      send_byte((r == 0) ? 8'h78 : ((r == 1) ? K_CR : K_LF), 1'b1);
    end
    sif.set_ready = 1'b1;
    wait_clks(4);
    check("all_delivered", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
